info_uart_tx: RTL
=================

# info_uart_tx

Serial reporter for the data memory's `info` word (bytes 252..255, big-endian). Watches the 32-bit `info` output and transmits it as four 8N1 UART bytes, most-significant byte first, whenever it changes or on request. This lets a running program publish a result by storing to address 252 and have it visible on a host terminal. Sits directly downstream of the data memory and consumes only its `info` port.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit; must be ≥ 2 (434 = 50 MHz / 115200).
- `SEND_ON_CHANGE`, 1, when 1 any difference between `info` and the last transmitted word triggers a frame; when 0 only `send` triggers.

- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `info`  input  32  word from data memory bytes 252..255; byte 252 is `info[31:24]`.
- `send`  input  1  request to transmit current `info`; sampled only in IDLE.
- `tx`  output  1  UART line, idle high.
- `busy`  output  1  high while a frame is in progress.
- `done`  output  1  one-cycle pulse when the fourth stop bit completes.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, state=IDLE, `last_sent`=0, all counters 0.
- Trigger, evaluated only in IDLE:
  - `send`=1; or
  - `SEND_ON_CHANGE`=1 and `info` != `last_sent`.
- On trigger, `info` is latched into `shift_word`, `last_sent` is set to `info`, byte index is set to 0, and the state goes to START.
- Frame layout: 4 bytes, `shift_word[31:24]` first.
- Each byte: start bit (0), 8 data bits LSB first, stop bit (1). No idle gap between bytes.
- States and transitions:
  - IDLE → START on trigger.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after the 8th bit.
  - STOP → START if byte index < 3, incrementing byte index.
  - STOP → IDLE if byte index = 3.
- Baud counter runs 0..`CLKS_PER_BIT`-1. Width is clog2(`CLKS_PER_BIT`). It wraps at each bit boundary. Bit index is 0..7; byte index is 0..3.
- `info` changes during a frame do not affect the frame in progress. Because `last_sent` holds the old value, the change fires a new frame on return to IDLE. The newest value is therefore always reported eventually; intermediate values may be skipped.
- `send` while busy is ignored, not queued.
- `send` together with a change condition produces a single frame.
- Reset mid-frame aborts immediately: `tx`=1 on the next cycle and `last_sent`=0. If `info` is non-zero after reset, a fresh full frame follows.

## Timing
- Trigger sampled at edge N. From N+1: `busy`=1 and `tx`=0 (start bit of byte 0).
- Each bit is held exactly `CLKS_PER_BIT` cycles. The full frame is 40·`CLKS_PER_BIT` cycles.
- At the edge ending the last stop bit: state=IDLE, `busy`=0, and `done`=1 for that one cycle.
- Back-to-back frames: the `done` cycle is an IDLE cycle and may itself trigger. The next start bit then begins one cycle later, i.e. there is a minimum of 1 idle-high cycle between frames.
- `tx` is driven from a register (glitch-free). There is no combinational path from `info` or `send` to `tx`.

## Structure
- Shared package `uart_pkg`:
  - state enum {IDLE, START, DATA, STOP};
  - `BITS_PER_BYTE`=8;
  - `BYTES_PER_WORD`=4.
- Natural sub-module: `uart_tx_byte`.
  - Handles byte serialization: start/ready handshake, baud counter, bit counter.
  - `info_uart_tx` keeps the word-level sequencing, change detection and `done`.
- Target: roughly 150–250 lines total.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, so one frame = 160 cycles.
1. Reset, `info`=0, 300 cycles → `tx`=1, `busy`=0, `done` never asserted.
2. `info`=0x12345678 → bytes 0x12, 0x34, 0x56, 0x78 decoded on `tx`. Byte 0 data bits are 0,1,0,0,1,0,0,0, each 4 cycles long. `done` pulses exactly 160 cycles after the first low cycle.
3. `info`=0x12345678, then `info`=0xDEADBEEF at cycle 50 of the frame → first frame is still 0x12345678. A second frame 0xDEADBEEF starts its start bit 1 cycle after `done`.
4. Idle with `info` unchanged, pulse `send` → identical frame retransmitted. Pulse `send` again at cycle 30 of that frame → exactly one frame, no extra frame afterward.
5. `rst` at cycle 70 of a 0xCAFEF00D frame → `tx`=1 and `busy`=0 on the next cycle. After release, a complete 0xCAFEF00D frame starts with no partial bytes.
6. `SEND_ON_CHANGE`=0, `info` toggles between 1 and 2 every 100 cycles → no frames. A single `send` → one frame carrying the value present at the sampling edge.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and framing constants for the UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  localparam int BITS_PER_BYTE = 8;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer with baud and bit counters and a registered tx line
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       ready_o,
  output logic       last_o
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic tx_q, tx_d, bit_end;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
    end
  end
  // a new byte may be accepted at the end of STOP so bytes run back to back
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = start_i ? START : IDLE;
      START: state_d = bit_end ? DATA : START;
      DATA: state_d = (bit_end && bit_q == 3'(BITS_PER_BYTE - 1)) ? STOP : DATA;
      STOP: state_d = bit_end ? (start_i ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bit_end = baud_q == BW'(CLKS_PER_BIT - 1);
    last_o = state_q == STOP && bit_end;
    ready_o = state_q == IDLE || last_o;
    baud_d = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
    bit_d = state_q != DATA ? '0 : bit_q + 3'(bit_end);
    sh_d = (ready_o && start_i) ? data_i : (state_q == DATA && bit_end) ? sh_q >> 1 : sh_q;
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
  end
  assign tx_o = tx_q;
endmodule

// File: rtl/info_uart_tx.sv
// info_uart_tx: transmits the 32-bit info word MSB byte first as four 8N1 bytes on change or request
module info_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter bit SEND_ON_CHANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] info,
  input  logic        send,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  logic busy_q, busy_d, done_q, done_d;
  logic [1:0] idx_q, idx_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] last_q, last_d;
  logic ready, byte_last, trigger, next_byte, fin;
  logic [7:0] byte_data;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk(clk),
    .rst(rst),
    .start_i(trigger | next_byte),
    .data_i(byte_data),
    .tx_o(tx),
    .ready_o(ready),
    .last_o(byte_last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q <= '0;
      shift_q <= '0;
      last_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      last_q <= last_d;
    end
  end
  // shift_q holds only the bytes still to send; byte 0 goes straight from info
  always_comb begin
    trigger = ready && !busy_q && (send || (SEND_ON_CHANGE && info != last_q));
    next_byte = byte_last && idx_q != 2'(BYTES_PER_WORD - 1);
    fin = byte_last && idx_q == 2'(BYTES_PER_WORD - 1);
    byte_data = trigger ? info[31:24] : shift_q[23:16];
    shift_d = trigger ? info[23:0] : next_byte ? {shift_q[15:0], 8'h00} : shift_q;
    last_d = trigger ? info : last_q;
    idx_d = trigger ? '0 : next_byte ? idx_q + 1'b1 : idx_q;
    busy_d = trigger | (busy_q & ~fin);
    done_d = fin;
  end
  assign busy = busy_q;
  assign done = done_q;
endmodule
